// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  cpu_pkg
//  Opcodes, ALU codes, sequencer state encoding and instruction classes.
//  Revision: 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [4:0] OP_JAL  = 5'b10100;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00000;

    localparam logic [3:0] ST_RST  = 4'd0;
    localparam logic [3:0] ST_T0   = 4'd1;
    localparam logic [3:0] ST_T1   = 4'd2;
    localparam logic [3:0] ST_T2   = 4'd3;
    localparam logic [3:0] ST_T3   = 4'd4;
    localparam logic [3:0] ST_T4   = 4'd5;
    localparam logic [3:0] ST_T5   = 4'd6;
    localparam logic [3:0] ST_T6   = 4'd7;
    localparam logic [3:0] ST_HALT = 4'd8;

    typedef enum logic [2:0] {
        CLS_NOP  = 3'd0,
        CLS_JAL  = 3'd1,
        CLS_JR   = 3'd2,
        CLS_ADDI = 3'd3,
        CLS_HALT = 3'd4
    } instr_cls_t;

endpackage
`default_nettype wire

// File: rtl/control_unit_if.sv
`default_nettype none
// ============================================================================
//  control_unit_if
//  Control strobes and IR/handshake between the sequencer and the Datapath.
//  Revision: 1.0
// ============================================================================
interface control_unit_if #(
    parameter int CTLW = 5
);
    logic [31:0]     IR;
    logic            Stop;
    logic            Run;
    logic [CTLW-1:0] CONTROL;
    logic IncPC, Read, PC_Out, MDR_Out, ZLO_Out, C_Out, PC_In, MDR_In;
    logic MAR_In, IR_In, Y_In, ZLO_In, G_RA, G_RB, R_Out, R_In;

    modport master (
        input  IR, Stop,
        output Run, CONTROL,
        output IncPC, Read, PC_Out, MDR_Out, ZLO_Out, C_Out, PC_In, MDR_In,
        output MAR_In, IR_In, Y_In, ZLO_In, G_RA, G_RB, R_Out, R_In
    );

    modport slave (
        output IR, Stop,
        input  Run, CONTROL,
        input  IncPC, Read, PC_Out, MDR_Out, ZLO_Out, C_Out, PC_In, MDR_In,
        input  MAR_In, IR_In, Y_In, ZLO_In, G_RA, G_RB, R_Out, R_In
    );
endinterface
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ============================================================================
//  control_decode
//  Maps the latched opcode to an instruction class; unknown opcodes act as nop.
//  Revision: 1.0
// ============================================================================
module control_decode
    import cpu_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] op_i,
    output instr_cls_t     cls_o
);

    always_comb begin
        cls_o = CLS_NOP;
        case (op_i)
            OPW'(OP_JAL):  cls_o = CLS_JAL;
            OPW'(OP_JR):   cls_o = CLS_JR;
            OPW'(OP_ADDI): cls_o = CLS_ADDI;
            OPW'(OP_HALT): cls_o = CLS_HALT;
            default:       cls_o = CLS_NOP;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  control_unit
//  Hardwired Moore T-state sequencer: fetch/decode, then per-opcode execute.
//  Revision: 1.0
// ============================================================================
module control_unit
    import cpu_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int CTLW = 5
) (
    input  logic           Clock,
    input  logic           Clear,
    control_unit_if.master bus
);

    logic [3:0]     state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    instr_cls_t     w_cls;
    logic [3:0]     w_boundary;

    control_decode #(.OPW(OPW)) u_decode (
        .op_i  (op_q),
        .cls_o (w_cls)
    );

    // Stop is only honoured where T0 would otherwise be entered.
    assign w_boundary = bus.Stop ? ST_HALT : ST_T0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RST:  state_d = w_boundary;
            ST_T0:   state_d = ST_T1;
            ST_T1:   state_d = ST_T2;
            ST_T2:   state_d = ST_T3;
            ST_T3: begin
                case (w_cls)
                    CLS_JAL, CLS_ADDI: state_d = ST_T4;
                    CLS_HALT:          state_d = ST_HALT;
                    default:           state_d = w_boundary;
                endcase
            end
            ST_T4:   state_d = ST_T5;
            ST_T5:   state_d = (w_cls == CLS_JAL) ? ST_T6 : w_boundary;
            ST_T6:   state_d = w_boundary;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    assign op_d = (state_q == ST_T2) ? bus.IR[31 -: OPW] : op_q;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= ST_RST;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    assign bus.Run     = (state_q != ST_HALT);
    assign bus.CONTROL = CTLW'(ALU_ADD);

    always_comb begin
        bus.IncPC   = 1'b0;
        bus.Read    = 1'b0;
        bus.PC_Out  = 1'b0;
        bus.MDR_Out = 1'b0;
        bus.ZLO_Out = 1'b0;
        bus.C_Out   = 1'b0;
        bus.PC_In   = 1'b0;
        bus.MDR_In  = 1'b0;
        bus.MAR_In  = 1'b0;
        bus.IR_In   = 1'b0;
        bus.Y_In    = 1'b0;
        bus.ZLO_In  = 1'b0;
        bus.G_RA    = 1'b0;
        bus.G_RB    = 1'b0;
        bus.R_Out   = 1'b0;
        bus.R_In    = 1'b0;
        case (state_q)
            ST_T0: begin
                bus.PC_Out = 1'b1;
                bus.MAR_In = 1'b1;
                bus.IncPC  = 1'b1;
            end
            ST_T1: begin
                bus.Read   = 1'b1;
                bus.MDR_In = 1'b1;
            end
            ST_T2: begin
                bus.MDR_Out = 1'b1;
                bus.IR_In   = 1'b1;
            end
            ST_T3: begin
                case (w_cls)
                    CLS_JAL: begin
                        bus.PC_Out = 1'b1;
                        bus.Y_In   = 1'b1;
                    end
                    CLS_JR: begin
                        bus.G_RA  = 1'b1;
                        bus.R_Out = 1'b1;
                        bus.PC_In = 1'b1;
                    end
                    CLS_ADDI: begin
                        bus.G_RB  = 1'b1;
                        bus.R_Out = 1'b1;
                        bus.Y_In  = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                bus.C_Out  = 1'b1;
                bus.ZLO_In = 1'b1;
            end
            ST_T5: begin
                bus.ZLO_Out = 1'b1;
                bus.R_In    = 1'b1;
                // jal writes the link register through RB, addi its result through RA
                bus.G_RB    = (w_cls == CLS_JAL);
                bus.G_RA    = (w_cls != CLS_JAL);
            end
            ST_T6: begin
                bus.G_RA  = 1'b1;
                bus.R_Out = 1'b1;
                bus.PC_In = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  tb_control_unit
//  Directed-vector bench for the control sequencer with hand-computed strobes.
//  Revision: 1.0
// ============================================================================
module tb_control_unit;

    localparam logic [15:0] S_INCPC   = 16'h8000;
    localparam logic [15:0] S_READ    = 16'h4000;
    localparam logic [15:0] S_PC_OUT  = 16'h2000;
    localparam logic [15:0] S_MDR_OUT = 16'h1000;
    localparam logic [15:0] S_ZLO_OUT = 16'h0800;
    localparam logic [15:0] S_C_OUT   = 16'h0400;
    localparam logic [15:0] S_PC_IN   = 16'h0200;
    localparam logic [15:0] S_MDR_IN  = 16'h0100;
    localparam logic [15:0] S_MAR_IN  = 16'h0080;
    localparam logic [15:0] S_IR_IN   = 16'h0040;
    localparam logic [15:0] S_Y_IN    = 16'h0020;
    localparam logic [15:0] S_ZLO_IN  = 16'h0010;
    localparam logic [15:0] S_G_RA    = 16'h0008;
    localparam logic [15:0] S_G_RB    = 16'h0004;
    localparam logic [15:0] S_R_OUT   = 16'h0002;
    localparam logic [15:0] S_R_IN    = 16'h0001;

    logic Clock = 1'b0;
    logic Clear;
    int   n_checks = 0;
    int   n_fail   = 0;

    control_unit_if #(.CTLW(5)) bus ();

    control_unit #(.OPW(5), .CTLW(5)) dut (
        .Clock (Clock),
        .Clear (Clear),
        .bus   (bus.master)
    );

    always #5 Clock = ~Clock;

    function automatic logic [31:0] observed();
        return {10'd0, bus.CONTROL, bus.Run,
                bus.IncPC, bus.Read, bus.PC_Out, bus.MDR_Out, bus.ZLO_Out, bus.C_Out,
                bus.PC_In, bus.MDR_In, bus.MAR_In, bus.IR_In, bus.Y_In, bus.ZLO_In,
                bus.G_RA, bus.G_RB, bus.R_Out, bus.R_In};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // CONTROL is always ADD (0), so expected word = {Run, strobes}.
    task automatic step(input string tag, input logic [15:0] exp_s, input logic exp_run);
        @(posedge Clock);
        #1;
        check(tag, observed(), {15'd0, exp_run, exp_s});
    endtask

    task automatic fetch(input string tag);
        step({tag, "_T0"}, S_PC_OUT | S_MAR_IN | S_INCPC, 1'b1);
        step({tag, "_T1"}, S_READ | S_MDR_IN, 1'b1);
        step({tag, "_T2"}, S_MDR_OUT | S_IR_IN, 1'b1);
    endtask

    task automatic reset_pulse();
        @(negedge Clock);
        Clear = 1'b0;
        #1;
        check("rst_async", observed(), {15'd0, 1'b1, 16'h0000});
        @(negedge Clock);
        Clear = 1'b1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Clear    = 1'b0;
        bus.Stop = 1'b0;
        bus.IR   = 32'h0;

        for (int i = 0; i < 3; i++) step("reset_hold", 16'h0000, 1'b1);
        @(negedge Clock);
        Clear = 1'b1;

        // jal
        bus.IR = 32'hA0F80001;
        fetch("jal");
        step("jal_T3", S_PC_OUT | S_Y_IN, 1'b1);
        step("jal_T4", S_C_OUT | S_ZLO_IN, 1'b1);
        step("jal_T5", S_ZLO_OUT | S_G_RB | S_R_IN, 1'b1);
        step("jal_T6", S_G_RA | S_R_OUT | S_PC_IN, 1'b1);

        // jr
        bus.IR = 32'h98800000;
        fetch("jr");
        step("jr_T3", S_G_RA | S_R_OUT | S_PC_IN, 1'b1);

        // addi
        bus.IR = 32'h61180005;
        fetch("addi");
        step("addi_T3", S_G_RB | S_R_OUT | S_Y_IN, 1'b1);
        step("addi_T4", S_C_OUT | S_ZLO_IN, 1'b1);
        step("addi_T5", S_ZLO_OUT | S_G_RA | S_R_IN, 1'b1);

        // unknown opcode behaves as nop
        bus.IR = 32'hF8000000;
        fetch("unk");
        step("unk_T3", 16'h0000, 1'b1);

        // nop with a Stop pulse inside T1..T2 has no effect
        bus.IR = 32'hD0000000;
        step("nop_T0", S_PC_OUT | S_MAR_IN | S_INCPC, 1'b1);
        step("nop_T1", S_READ | S_MDR_IN, 1'b1);
        bus.Stop = 1'b1;
        step("nop_T2", S_MDR_OUT | S_IR_IN, 1'b1);
        bus.Stop = 1'b0;
        step("nop_T3", 16'h0000, 1'b1);

        // jal with Stop raised in T4 completes, then halts
        bus.IR = 32'hA0F80001;
        fetch("jstop");
        step("jstop_T3", S_PC_OUT | S_Y_IN, 1'b1);
        step("jstop_T4", S_C_OUT | S_ZLO_IN, 1'b1);
        bus.Stop = 1'b1;
        step("jstop_T5", S_ZLO_OUT | S_G_RB | S_R_IN, 1'b1);
        step("jstop_T6", S_G_RA | S_R_OUT | S_PC_IN, 1'b1);
        step("jstop_halt", 16'h0000, 1'b0);
        step("jstop_halt2", 16'h0000, 1'b0);
        bus.Stop = 1'b0;
        reset_pulse();

        // halt instruction
        bus.IR = 32'hD8000000;
        fetch("halt");
        step("halt_T3", 16'h0000, 1'b1);
        for (int i = 0; i < 20; i++) step("halt_hold", 16'h0000, 1'b0);
        reset_pulse();

        // asynchronous reset in the middle of jal T5
        bus.IR = 32'hA0F80001;
        fetch("ajal");
        step("ajal_T3", S_PC_OUT | S_Y_IN, 1'b1);
        step("ajal_T4", S_C_OUT | S_ZLO_IN, 1'b1);
        step("ajal_T5", S_ZLO_OUT | S_G_RB | S_R_IN, 1'b1);
        #2;
        Clear = 1'b0;
        #1;
        check("ajal_async_clear", observed(), {15'd0, 1'b1, 16'h0000});
        @(negedge Clock);
        Clear = 1'b1;
        fetch("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
